xbar_cfg_arbiter: RTL
=====================

# xbar_cfg_arbiter

Shares the crossbar configuration register file between the SPI adapter path and the Wishbone slave port inside the interconnect. Accepts one transaction at a time from either requester under round-robin arbitration, writes or reads the per-crossbar select registers, and returns a response on the originating port. Pad-driven crossbar override inputs are synchronized here and block writes to an overridden crossbar.

## Interface
- NUM_XBARS, 3, number of crossbars (input, classifier, output)
- CFG_W, 8, width of one crossbar config register
- ADDR_W, 2, register address width; must satisfy 2**ADDR_W >= NUM_XBARS

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- spi_req_val / spi_req_rdy  in / out  1  SPI request handshake
- spi_req_wen  in  1  1 = write, 0 = read
- spi_req_addr  in  ADDR_W  crossbar index
- spi_req_data  in  CFG_W  write data
- spi_resp_val / spi_resp_rdy  out / in  1  SPI response handshake
- spi_resp_data  out  CFG_W  read data; 0 for writes
- spi_resp_err  out  1  request rejected
- wb_req_val, wb_req_rdy, wb_req_wen, wb_req_addr, wb_req_data, wb_resp_val, wb_resp_rdy, wb_resp_data, wb_resp_err  same as spi_*, Wishbone requester
- xbar_override  in  NUM_XBARS  asynchronous pad override per crossbar
- xbar_cfg  out  NUM_XBARS*CFG_W  config registers, crossbar i at bits [i*CFG_W +: CFG_W]
- xbar_cfg_upd  out  NUM_XBARS  one-cycle pulse when crossbar i's register is written

## Operation
- FSM states: IDLE, RESP.
- IDLE: round-robin grant among valid requesters; pointer starts at SPI after reset; req_rdy of granted requester high combinationally; other req_rdy low.
- Accept on req_val & req_rdy: perform access, capture response, set owner, flip pointer to the other requester, go to RESP.
- RESP: all req_rdy low; owner's resp_val high; on resp_val & resp_rdy return to IDLE.
- Write, addr < NUM_XBARS, synced override low: register updated, err=0, data=0.
- Write, override high: no update, no upd pulse, err=1.
- Any access with addr >= NUM_XBARS: no update, err=1, data=0.
- Read, valid addr: data = register value, err=0 (override does not block reads).
- xbar_override passes through 2-flop synchronizer before use.

## Timing
- Reset values: xbar_cfg all 0, xbar_cfg_upd 0, all resp_val/resp_data/resp_err 0, state IDLE, pointer = SPI, synchronizers 0.
- Accept at edge N -> resp_val high from cycle N+1; xbar_cfg and xbar_cfg_upd change at edge N (upd high during cycle N+1 only).
- Response held stable until resp_rdy; minimum 2 cycles per transaction.
- Both requesters valid in IDLE: pointer holder granted; other granted on next IDLE.
- Override change affects decisions 2 cycles after pad edge.
- Reset mid-transaction: response dropped, registers cleared, no upd pulse.

## Configuration
- XBAR_CFG_ARB_READBACK_EN: defined -> reads return register value. Undefined -> reads return data=0, err=0; read logic not synthesized.

## Structure
- Package xbar_cfg_arb_pkg: state enum, requester id constants (REQ_SPI=0, REQ_WB=1), default NUM_XBARS/CFG_W.
- Sub-module xbar_cfg_rr2: two-requester round-robin arbiter (val in, grant out, pointer update on accept).

## Test plan
- Reset, SPI write addr 1 data 0x5A -> spi_resp_val next cycle, err=0; xbar_cfg[15:8]=0x5A; xbar_cfg_upd=3'b010 one cycle.
- SPI and WB both valid, writing addr 0 with 0x11 / 0x22 -> SPI served first, WB second; final xbar_cfg[7:0]=0x22.
- xbar_override[2]=1 for 3 cycles, WB write addr 2 data 0xFF -> wb_resp_err=1, xbar_cfg[23:16] unchanged, no upd pulse.
- Write addr 3 -> err=1, data 0; no register changes.
- Read addr 1 after first test with wb_resp_rdy low 4 cycles -> resp_val and data 0x5A held stable (0 without READBACK_EN); SPI request stalled (spi_req_rdy=0).
- Assert reset during RESP -> resp_val 0, xbar_cfg 0 immediately, state IDLE after release.

Source files
------------

// File: rtl/xbar_cfg_arb_pkg.sv
// ---------------------------------------------------------------------------
// xbar_cfg_arb_pkg
//   Shared types and defaults for the crossbar configuration arbiter.
//   - state_t     : two-state transaction FSM (IDLE / RESP)
//   - REQ_SPI/WB  : requester ids; also the grant-vector bit positions
//   - DEF_*       : default sizing (3 crossbars, 8-bit select registers)
//   Optional feature macro used by the arbiter: XBAR_CFG_ARB_READBACK_EN.
// ---------------------------------------------------------------------------
package xbar_cfg_arb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  localparam logic REQ_SPI = 1'b0;
  localparam logic REQ_WB  = 1'b1;

  localparam int DEF_NUM_XBARS = 3;
  localparam int DEF_CFG_W     = 8;
  localparam int DEF_ADDR_W    = 2;

  // Id of the requester that is not 'id'; used for the round-robin flip.
  function automatic logic other_req(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/xbar_cfg_rr2.sv
// ---------------------------------------------------------------------------
// xbar_cfg_rr2
//   Two-requester round-robin arbiter. The pointer names the requester that
//   wins a tie; after every accepted grant it moves to the other requester.
//   Ports:
//     i_clk, i_rst_n  clock, async active-low reset (pointer -> REQ_SPI)
//     i_val[1:0]      request valid, bit REQ_SPI / REQ_WB
//     i_accept        grant was taken this cycle (val & rdy at the top)
//     o_gnt[1:0]      one-hot grant, zero when nobody is requesting
//     o_gnt_id        id of the granted requester (meaningful when o_gnt!=0)
// ---------------------------------------------------------------------------
module xbar_cfg_rr2
  import xbar_cfg_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_val,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_gnt_id
);

  logic r_ptr;
  logic w_gnt_id;

  // Pointer holder wins if it is requesting, otherwise the other side.
  always_comb begin
    w_gnt_id = i_val[r_ptr] ? r_ptr : other_req(r_ptr);
    o_gnt    = '0;
    if (i_val[w_gnt_id]) o_gnt[w_gnt_id] = 1'b1;
  end

  assign o_gnt_id = w_gnt_id;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_ptr <= REQ_SPI;
    else if (i_accept) r_ptr <= other_req(w_gnt_id);
  end

endmodule

// File: rtl/xbar_cfg_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_cfg_arbiter
//   Shares the crossbar select register file between the SPI adapter and the
//   Wishbone slave. One transaction in flight at a time; the response is
//   returned on the port that issued it. Pad override inputs are
//   double-flopped and, when high, reject writes to that crossbar.
//   Optional feature: define XBAR_CFG_ARB_READBACK_EN to let reads return
//   the register value; without it reads complete with data 0, err 0.
//   Ports:
//     i_clk, i_rst_n                   clock, async active-low reset
//     i_spi_req_* / o_spi_req_rdy      SPI request (val, wen, addr, data)
//     o_spi_resp_* / i_spi_resp_rdy    SPI response (val, data, err)
//     i_wb_req_*  / o_wb_req_rdy       Wishbone request
//     o_wb_resp_* / i_wb_resp_rdy      Wishbone response
//     i_xbar_override[NUM_XBARS]       asynchronous pad override
//     o_xbar_cfg[NUM_XBARS*CFG_W]      registers, xbar i at [i*CFG_W +: CFG_W]
//     o_xbar_cfg_upd[NUM_XBARS]        one-cycle pulse per written register
// ---------------------------------------------------------------------------
module xbar_cfg_arbiter
  import xbar_cfg_arb_pkg::*;
#(
  parameter int NUM_XBARS = DEF_NUM_XBARS,
  parameter int CFG_W     = DEF_CFG_W,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_spi_req_val,
  output logic                       o_spi_req_rdy,
  input  logic                       i_spi_req_wen,
  input  logic [ADDR_W-1:0]          i_spi_req_addr,
  input  logic [CFG_W-1:0]           i_spi_req_data,
  output logic                       o_spi_resp_val,
  input  logic                       i_spi_resp_rdy,
  output logic [CFG_W-1:0]           o_spi_resp_data,
  output logic                       o_spi_resp_err,
  input  logic                       i_wb_req_val,
  output logic                       o_wb_req_rdy,
  input  logic                       i_wb_req_wen,
  input  logic [ADDR_W-1:0]          i_wb_req_addr,
  input  logic [CFG_W-1:0]           i_wb_req_data,
  output logic                       o_wb_resp_val,
  input  logic                       i_wb_resp_rdy,
  output logic [CFG_W-1:0]           o_wb_resp_data,
  output logic                       o_wb_resp_err,
  input  logic [NUM_XBARS-1:0]       i_xbar_override,
  output logic [NUM_XBARS*CFG_W-1:0] o_xbar_cfg,
  output logic [NUM_XBARS-1:0]       o_xbar_cfg_upd
);

  // One extra bit so the range check stays correct when 2**ADDR_W == NUM_XBARS.
  localparam int AX_W = ADDR_W + 1;

  state_t                           r_state, w_state_nxt;
  logic                             r_owner;
  logic [CFG_W-1:0]                 r_resp_data;
  logic                             r_resp_err;
  logic [NUM_XBARS-1:0][CFG_W-1:0]  r_cfg;
  logic [NUM_XBARS-1:0]             r_upd;
  logic [NUM_XBARS-1:0]             r_ovr_s1, r_ovr_s2;

  logic [1:0]                       w_val, w_gnt;
  logic                             w_gnt_id;
  logic                             w_spi_req_rdy, w_wb_req_rdy;
  logic                             w_acc;
  logic                             w_resp_val, w_resp_rdy, w_resp_hs;
  logic                             w_wen;
  logic [ADDR_W-1:0]                w_addr;
  logic [CFG_W-1:0]                 w_wdata;
  logic                             w_addr_ok;
  logic [NUM_XBARS-1:0]             w_sel;
  logic                             w_ovr_sel;
  logic                             w_wr_ok;
  logic [NUM_XBARS-1:0]             w_upd_nxt;
  logic [CFG_W-1:0]                 w_rd_data;
  logic [CFG_W-1:0]                 w_resp_data_nxt;
  logic                             w_resp_err_nxt;

  // ---- override synchronizer -------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ovr_s1 <= '0;
      r_ovr_s2 <= '0;
    end else begin
      r_ovr_s1 <= i_xbar_override;
      r_ovr_s2 <= r_ovr_s1;
    end
  end

  // ---- arbitration -----------------------------------------------------
  assign w_val[REQ_SPI] = i_spi_req_val;
  assign w_val[REQ_WB]  = i_wb_req_val;

  xbar_cfg_rr2 u_rr2 (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_val    (w_val),
    .i_accept (w_acc),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  // ---- FSM: state register ---------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---- FSM: next state -------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_acc)     w_state_nxt = S_RESP;
      S_RESP:  if (w_resp_hs) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----------------------------------------------------
  always_comb begin
    w_spi_req_rdy = 1'b0;
    w_wb_req_rdy  = 1'b0;
    w_resp_val    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_spi_req_rdy = w_gnt[REQ_SPI];
        w_wb_req_rdy  = w_gnt[REQ_WB];
      end
      S_RESP:  w_resp_val = 1'b1;
      default: ;
    endcase
  end

  assign w_acc      = (w_spi_req_rdy & i_spi_req_val) | (w_wb_req_rdy & i_wb_req_val);
  assign w_resp_rdy = (r_owner == REQ_WB) ? i_wb_resp_rdy : i_spi_resp_rdy;
  assign w_resp_hs  = w_resp_val & w_resp_rdy;

  assign o_spi_req_rdy   = w_spi_req_rdy;
  assign o_wb_req_rdy    = w_wb_req_rdy;
  assign o_spi_resp_val  = w_resp_val & (r_owner == REQ_SPI);
  assign o_wb_resp_val   = w_resp_val & (r_owner == REQ_WB);
  assign o_spi_resp_data = (r_owner == REQ_SPI) ? r_resp_data : '0;
  assign o_wb_resp_data  = (r_owner == REQ_WB)  ? r_resp_data : '0;
  assign o_spi_resp_err  = (r_owner == REQ_SPI) & r_resp_err;
  assign o_wb_resp_err   = (r_owner == REQ_WB)  & r_resp_err;

  // ---- request decode --------------------------------------------------
  assign w_wen   = (w_gnt_id == REQ_WB) ? i_wb_req_wen  : i_spi_req_wen;
  assign w_addr  = (w_gnt_id == REQ_WB) ? i_wb_req_addr : i_spi_req_addr;
  assign w_wdata = (w_gnt_id == REQ_WB) ? i_wb_req_data : i_spi_req_data;

  assign w_addr_ok = {1'b0, w_addr} < AX_W'(NUM_XBARS);

  // One-hot register select; stays zero for out-of-range addresses.
  always_comb begin
    w_sel     = '0;
    w_ovr_sel = 1'b0;
    for (int i = 0; i < NUM_XBARS; i++) begin
      if (w_addr == ADDR_W'(i)) begin
        w_sel[i]  = 1'b1;
        w_ovr_sel = r_ovr_s2[i];
      end
    end
  end

`ifdef XBAR_CFG_ARB_READBACK_EN
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_XBARS; i++)
      if (w_sel[i]) w_rd_data = r_cfg[i];
  end
`else
  assign w_rd_data = '0;
`endif

  assign w_wr_ok         = w_wen & w_addr_ok & ~w_ovr_sel;
  assign w_upd_nxt       = (w_acc & w_wr_ok) ? w_sel : '0;
  assign w_resp_err_nxt  = ~w_addr_ok | (w_wen & w_ovr_sel);
  // Writes and rejected accesses always answer with zero data.
  assign w_resp_data_nxt = (~w_wen & w_addr_ok) ? w_rd_data : '0;

  // ---- register file and response capture ------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg       <= '0;
      r_upd       <= '0;
      r_owner     <= REQ_SPI;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      r_upd <= w_upd_nxt;
      for (int i = 0; i < NUM_XBARS; i++)
        if (w_upd_nxt[i]) r_cfg[i] <= w_wdata;
      if (w_acc) begin
        r_owner     <= w_gnt_id;
        r_resp_data <= w_resp_data_nxt;
        r_resp_err  <= w_resp_err_nxt;
      end
    end
  end

  assign o_xbar_cfg     = r_cfg;
  assign o_xbar_cfg_upd = r_upd;

endmodule
